// File: rtl/prbs_checker.sv
// ----------------------------------------------------------------------------
// prbs_checker
//   Receive-side BER monitor. Consumes the recovered data bit from the
//   bang-bang phase detector, self-synchronises a local Fibonacci LFSR to the
//   incoming PRBS, declares lock, counts checked and errored bits while
//   locked, and drops lock when too many errors land in one window.
//
//   State machine: SEED   - shift received bits into the LFSR to seed it
//                  VERIFY - free-run the LFSR, require LOCK_COUNT clean
//                           predictions in a row
//                  LOCKED - free-run the LFSR, count bits/errors, watch the
//                           per-window error count for loss of lock
//
// Ports
//   clk            in   RX recovered clock (rising edge)
//   rst_n          in   asynchronous active-low reset
//   en             in   qualifies `in`; state holds when low
//   in             in   recovered data bit
//   clr            in   synchronous clear of the statistics counters
//   locked         out  high while in LOCKED
//   lock_lost      out  one-cycle pulse on LOCKED -> SEED
//   bit_cnt        out  bits checked while locked (saturating)
//   err_cnt        out  errored bits while locked (saturating)
//   lock_lost_cnt  out  number of lock losses (saturating at 255)
//
// Build option
//   PRBS_CHK_FIRST_ERR_EN : adds first_err_valid / first_err_idx, which
//   capture the bit_cnt position of the first error seen while locked since
//   reset or the last clr.
// ----------------------------------------------------------------------------
module prbs_checker #(
    parameter int PRBS_WIDTH  = 7,
    parameter int TAP_A       = 7,
    parameter int TAP_B       = 6,
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in,
    input  logic                 clr,
    output logic                 locked,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] bit_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [7:0]           lock_lost_cnt
`ifdef PRBS_CHK_FIRST_ERR_EN
    ,
    output logic                 first_err_valid,
    output logic [CNT_WIDTH-1:0] first_err_idx
`endif
);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int FILL_W  = $clog2(PRBS_WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);
    // One extra bit so the running error sum including the current bit can
    // be compared against the threshold without overflow.
    localparam int WSUM_W  = WERR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q,     state_d;
    logic [PRBS_WIDTH-1:0] sr_q,        sr_d;
    logic [FILL_W-1:0]     fill_q,      fill_d;
    logic [MATCH_W-1:0]    match_q,     match_d;
    logic [WIN_W-1:0]      window_q,    window_d;
    logic [WERR_W-1:0]     win_err_q,   win_err_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q,   err_cnt_d;
    logic [7:0]            ll_cnt_q,    ll_cnt_d;
    logic                  lock_lost_q, lock_lost_d;

    // ------------------------------------------------------------------
    // Prediction / compare
    // ------------------------------------------------------------------
    logic pred;
    logic err;
    logic bit_inc;
    logic err_inc;
    logic ll_inc;

    logic [FILL_W-1:0]  fill_nxt;
    logic [MATCH_W-1:0] match_nxt;
    logic [WIN_W-1:0]   window_nxt;
    logic [WSUM_W-1:0]  win_err_sum;

    // sr[0] holds the newest bit, so sr[k-1] is the bit from k cycles ago.
    assign pred = sr_q[TAP_A-1] ^ sr_q[TAP_B-1];
    assign err  = in ^ pred;

    assign fill_nxt    = fill_q + 1'b1;
    assign match_nxt   = match_q + 1'b1;
    assign window_nxt  = window_q + 1'b1;
    assign win_err_sum = {1'b0, win_err_q} + WSUM_W'(err);

    // ------------------------------------------------------------------
    // FSM and LFSR
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        window_d    = window_q;
        win_err_d   = win_err_q;
        lock_lost_d = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;
        ll_inc      = 1'b0;

        if (en) begin
            case (state_q)
                ST_SEED: begin
                    // Load the received bits verbatim until the register
                    // holds a full PRBS_WIDTH-bit history.
                    sr_d   = {sr_q[PRBS_WIDTH-2:0], in};
                    fill_d = fill_nxt;
                    if (fill_nxt == FILL_W'(PRBS_WIDTH)) begin
                        state_d = ST_VERIFY;
                        match_d = '0;
                    end
                end

                ST_VERIFY: begin
                    sr_d = {sr_q[PRBS_WIDTH-2:0], pred};
                    if (err) begin
                        state_d = ST_SEED;
                        fill_d  = '0;
                    end else begin
                        match_d = match_nxt;
                        if (match_nxt == MATCH_W'(LOCK_COUNT)) begin
                            state_d   = ST_LOCKED;
                            window_d  = '0;
                            win_err_d = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    // The LFSR free-runs on its own prediction so a received
                    // error never propagates into later predictions.
                    sr_d    = {sr_q[PRBS_WIDTH-2:0], pred};
                    bit_inc = 1'b1;
                    err_inc = err;
                    if (win_err_sum >= WSUM_W'(LOSS_THRESH)) begin
                        state_d     = ST_SEED;
                        fill_d      = '0;
                        window_d    = '0;
                        win_err_d   = '0;
                        lock_lost_d = 1'b1;
                        ll_inc      = 1'b1;
                    end else if (window_nxt == WIN_W'(LOSS_WINDOW)) begin
                        window_d  = '0;
                        win_err_d = '0;
                    end else begin
                        window_d  = window_nxt;
                        win_err_d = win_err_sum[WERR_W-1:0];
                    end
                end

                default: begin
                    state_d = ST_SEED;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters: saturate, clr wins over a same-cycle increment
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        ll_cnt_d  = ll_cnt_q;
        if (clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
            ll_cnt_d  = '0;
        end else begin
            if (bit_inc && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + 1'b1;
            if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
            if (ll_inc  && (ll_cnt_q  != '1)) ll_cnt_d  = ll_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            window_q    <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ll_cnt_q    <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            window_q    <= window_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ll_cnt_q    <= ll_cnt_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign locked        = (state_q == ST_LOCKED);
    assign lock_lost     = lock_lost_q;
    assign bit_cnt       = bit_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign lock_lost_cnt = ll_cnt_q;

`ifdef PRBS_CHK_FIRST_ERR_EN
    // ------------------------------------------------------------------
    // First-error capture: position is bit_cnt before this bit's increment
    // ------------------------------------------------------------------
    logic                 fe_valid_q, fe_valid_d;
    logic [CNT_WIDTH-1:0] fe_idx_q,   fe_idx_d;

    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_idx_d   = fe_idx_q;
        if (clr) begin
            fe_valid_d = 1'b0;
            fe_idx_d   = '0;
        end else if (err_inc && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_idx_d   = bit_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_valid_q <= 1'b0;
            fe_idx_q   <= '0;
        end else begin
            fe_valid_q <= fe_valid_d;
            fe_idx_q   <= fe_idx_d;
        end
    end

    assign first_err_valid = fe_valid_q;
    assign first_err_idx   = fe_idx_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// ----------------------------------------------------------------------------
// tb_prbs_checker
//   Two checkers share one stimulus stream: the default build and a narrow
//   CNT_WIDTH=4 build for counter saturation. Expected values are queued with
//   the cycle they become due when each bit is driven; a negedge monitor pops
//   and compares them.
// ----------------------------------------------------------------------------
module tb_prbs_checker;

    localparam int CW  = 32;
    localparam int CW4 = 4;

    localparam int S_LOCK  = 0;
    localparam int S_LL    = 1;
    localparam int S_BIT   = 2;
    localparam int S_ERR   = 3;
    localparam int S_LLC   = 4;
    localparam int S_D4LK  = 5;
    localparam int S_D4BIT = 6;
    localparam int S_D4ERR = 7;
    localparam int S_FEV   = 8;
    localparam int S_FEI   = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;
    logic clr4 = 1'b0;

    logic           locked, lock_lost;
    logic [CW-1:0]  bit_cnt, err_cnt;
    logic [7:0]     llc;
    logic           locked4, lock_lost4;
    logic [CW4-1:0] bit_cnt4, err_cnt4;
    logic [7:0]     llc4;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic           fev, fev4;
    logic [CW-1:0]  fei;
    logic [CW4-1:0] fei4;
`endif

    prbs_checker #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr),
        .locked(locked), .lock_lost(lock_lost), .bit_cnt(bit_cnt),
        .err_cnt(err_cnt), .lock_lost_cnt(llc)
`ifdef PRBS_CHK_FIRST_ERR_EN
        , .first_err_valid(fev), .first_err_idx(fei)
`endif
    );

    prbs_checker #(.CNT_WIDTH(CW4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr4),
        .locked(locked4), .lock_lost(lock_lost4), .bit_cnt(bit_cnt4),
        .err_cnt(err_cnt4), .lock_lost_cnt(llc4)
`ifdef PRBS_CHK_FIRST_ERR_EN
        , .first_err_valid(fev4), .first_err_idx(fei4)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        int          sig;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t sbq[$];

    task automatic expv(input int sig, input logic [63:0] val, input string tag);
        exp_t e;
        e.due = cyc + 1;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    function automatic logic [63:0] sample(input int sig);
        case (sig)
            S_LOCK:  return 64'(locked);
            S_LL:    return 64'(lock_lost);
            S_BIT:   return 64'(bit_cnt);
            S_ERR:   return 64'(err_cnt);
            S_LLC:   return 64'(llc);
            S_D4LK:  return 64'(locked4);
            S_D4BIT: return 64'(bit_cnt4);
            S_D4ERR: return 64'(err_cnt4);
`ifdef PRBS_CHK_FIRST_ERR_EN
            S_FEV:   return 64'(fev);
            S_FEI:   return 64'(fei);
`endif
            default: return 64'hDEAD;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk(e.tag, sample(e.sig), e.val);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Reference PRBS7 (x^7 + x^6 + 1), newest bit in g[0].
    logic [6:0] g = 7'h01;

    task automatic nbit(output logic b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    task automatic send(input logic e, input logic b, input logic c, input logic c4);
        @(negedge clk);
        en   = e;
        din  = b;
        clr  = c;
        clr4 = c4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : wdog
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    initial begin : main
        logic b;
        logic f;
        int   k;

        // Reset state
        #12;
        chk("rst_locked", 64'(locked), 0);
        chk("rst_ll", 64'(lock_lost), 0);
        chk("rst_bit", 64'(bit_cnt), 0);
        chk("rst_err", 64'(err_cnt), 0);
        chk("rst_llc", 64'(llc), 0);
        chk("rst_d4lock", 64'(locked4), 0);
`ifdef PRBS_CHK_FIRST_ERR_EN
        chk("rst_fev", 64'(fev), 0);
        chk("rst_fei", 64'(fei), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1. clean stream: lock on bit 23, then 1000 checked bits
        for (int i = 1; i <= 23; i++) begin
            nbit(b);
            send(1'b1, b, 1'b0, 1'b0);
            expv(S_LOCK, 64'(i == 23), "t1_lock");
            expv(S_D4LK, 64'(i == 23), "t1_d4lock");
        end
        for (int i = 1; i <= 1000; i++) begin
            nbit(b);
            send(1'b1, b, 1'b0, 1'b0);
            expv(S_LL, 0, "t1_ll");
            if (i == 20) begin
                expv(S_BIT, 20, "t1_bit20");
                expv(S_D4BIT, 15, "t5_d4sat");
                expv(S_D4ERR, 0, "t5_d4err");
            end
            if (i == 1000) begin
                expv(S_BIT, 1000, "t1_bit");
                expv(S_ERR, 0, "t1_err");
                expv(S_LOCK, 1, "t1_lock_hold");
            end
        end

        // 2. three isolated flips; narrow instance cleared on the first one
        for (int i = 0; i < 300; i++) begin
            nbit(b);
            f = (i == 50) || (i == 150) || (i == 250);
            send(1'b1, b ^ f, 1'b0, i == 50);
            expv(S_LL, 0, "t2_ll");
            expv(S_LOCK, 1, "t2_lock");
            if (i == 50) begin
                expv(S_D4BIT, 0, "t5_clr_bit");
                expv(S_D4ERR, 0, "t5_clr_err");
`ifdef PRBS_CHK_FIRST_ERR_EN
                expv(S_FEV, 1, "t2_fev");
                expv(S_FEI, 1050, "t2_fei");
`endif
            end
        end
        expv(S_ERR, 3, "t2_err");
        expv(S_BIT, 1300, "t2_bit");
        expv(S_D4BIT, 15, "t5_resat");
        expv(S_D4ERR, 2, "t5_d4err2");

        // 3. eight errors in one window -> loss, then relock after 23 bits
        for (int i = 0; i < 8; i++) begin
            nbit(b);
            send(1'b1, ~b, 1'b0, 1'b0);
            expv(S_LL, 64'(i == 7), "t3_ll");
            expv(S_LOCK, 64'(i != 7), "t3_lock");
        end
        expv(S_LLC, 1, "t3_llc");
        expv(S_ERR, 11, "t3_err");
        expv(S_BIT, 1308, "t3_bit");
        for (int i = 1; i <= 23; i++) begin
            nbit(b);
            send(1'b1, b, 1'b0, 1'b0);
            expv(S_LL, 0, "t3_ll_once");
            expv(S_LOCK, 64'(i == 23), "t3_relock");
        end
        expv(S_BIT, 1308, "t3_bit_hold");
        expv(S_LLC, 1, "t3_llc_hold");

        // clr together with an error bit on the wide instance
        nbit(b);
        send(1'b1, ~b, 1'b1, 1'b0);
        expv(S_BIT, 0, "clr_bit");
        expv(S_ERR, 0, "clr_err");
        expv(S_LLC, 0, "clr_llc");
        expv(S_LOCK, 1, "clr_lock");
`ifdef PRBS_CHK_FIRST_ERR_EN
        expv(S_FEV, 0, "clr_fev");
`endif
        nbit(b);
        send(1'b1, b, 1'b0, 1'b0);
        expv(S_BIT, 1, "clr_bit1");
        nbit(b);
        send(1'b1, ~b, 1'b0, 1'b0);
        expv(S_ERR, 1, "clr_err1");
        expv(S_BIT, 2, "clr_bit2");
`ifdef PRBS_CHK_FIRST_ERR_EN
        expv(S_FEV, 1, "clr_fev1");
        expv(S_FEI, 1, "clr_fei1");
`endif

        // 6b. async reset while locked: outputs drop without a clock edge
        @(negedge clk);
        chk("t6_pre_lock", 64'(locked), 1);
        #1;
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_async_lock", 64'(locked), 0);
        chk("t6_async_bit", 64'(bit_cnt), 0);
        chk("t6_async_err", 64'(err_cnt), 0);
        chk("t6_async_llc", 64'(llc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4. random enable; lock point counted in enabled bits only
        k = 0;
        for (int c = 0; c < 300; c++) begin
            f = 1'($urandom_range(0, 1));
            if (f) begin
                nbit(b);
                k++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            send(f, b, 1'b0, 1'b0);
            expv(S_LOCK, 64'(k >= 23), "t4_lock");
            expv(S_BIT, 64'((k > 23) ? (k - 23) : 0), "t4_bit");
        end

        // 6a. error at match=10 in VERIFY -> reseed, needs 23 more bits
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            nbit(b);
            send(1'b1, b, 1'b0, 1'b0);
            expv(S_LOCK, 0, "t6_pre");
        end
        nbit(b);
        send(1'b1, ~b, 1'b0, 1'b0);
        expv(S_LOCK, 0, "t6_verr");
        for (int i = 1; i <= 23; i++) begin
            nbit(b);
            send(1'b1, b, 1'b0, 1'b0);
            expv(S_LOCK, 64'(i == 23), "t6_relock");
        end

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        if (sbq.size() != 0) chk("sb_drain", 64'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
